// File: rtl/player_motion.sv
// -----------------------------------------------------------------------------
// player_motion
//   Keyboard-driven sprite position generator for the player character.
//   A horizontal FSM walks the sprite left/right at one pixel per step period,
//   clamped to the playfield. A vertical FSM runs a jump arc: constant-rate
//   deceleration while rising, accelerating fall up to a terminal velocity,
//   and landing back on the ground line. Both axes update independently.
//
// Ports
//   clk          in   1   system clock
//   rst          in   1   synchronous, active-high reset
//   keyCode      in   7   ASCII of the current key from the keyboard decoder
//   released     in   1   1 = key in keyCode released, 0 = held
//   xpos         out  12  sprite x (registered)
//   ypos         out  12  sprite y (registered, down = larger)
//   moving       out  1   horizontal FSM is in H_LEFT or H_RIGHT
//   facing_left  out  1   last horizontal direction, 1 = left
//   airborne     out  1   vertical FSM is in V_RISING or V_FALLING
// -----------------------------------------------------------------------------
module player_motion #(
   parameter int STEP_DIV = 80_000,
   parameter int JUMP_DIV = 200_000,
   parameter int X_MIN    = 0,
   parameter int X_MAX    = 1000,
   parameter int Y_TOP    = 0,
   parameter int Y_GROUND = 700,
   parameter int X_INIT   = 0,
   parameter int JUMP_V0  = 12,
   parameter int V_MAX    = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  keyCode,
   input  logic        released,
   output logic [11:0] xpos,
   output logic [11:0] ypos,
   output logic        moving,
   output logic        facing_left,
   output logic        airborne
);

   localparam int SW = (STEP_DIV > 0) ? $clog2(STEP_DIV + 1) : 1;
   localparam int TW = (JUMP_DIV > 0) ? $clog2(JUMP_DIV + 1) : 1;

   localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_DIV);
   localparam logic [SW-1:0] STEP_ONE   = SW'(1);
   localparam logic [TW-1:0] TICK_LAST  = TW'(JUMP_DIV);
   localparam logic [TW-1:0] TICK_ONE   = TW'(1);

   localparam logic [11:0] X_MIN_C    = 12'(X_MIN);
   localparam logic [11:0] X_MAX_C    = 12'(X_MAX);
   localparam logic [11:0] X_INIT_C   = 12'(X_INIT);
   localparam logic [11:0] Y_TOP_C    = 12'(Y_TOP);
   localparam logic [11:0] Y_GROUND_C = 12'(Y_GROUND);
   localparam logic [12:0] Y_TOP_W    = 13'(Y_TOP);
   localparam logic [12:0] Y_GROUND_W = 13'(Y_GROUND);
   localparam logic [5:0]  JUMP_V0_C  = 6'(JUMP_V0);
   localparam logic [5:0]  V_MAX_C    = 6'(V_MAX);
   localparam logic [6:0]  V_MAX_W    = 7'(V_MAX);

   typedef enum logic [1:0] {
      H_IDLE  = 2'd0,
      H_LEFT  = 2'd1,
      H_RIGHT = 2'd2
   } h_state_t;

   typedef enum logic [1:0] {
      V_GROUND  = 2'd0,
      V_RISING  = 2'd1,
      V_FALLING = 2'd2
   } v_state_t;

   // State and datapath registers
   h_state_t      h_state_q,   h_state_d;
   v_state_t      v_state_q,   v_state_d;
   logic [SW-1:0] step_cnt_q,  step_cnt_d;
   logic [TW-1:0] tick_cnt_q,  tick_cnt_d;
   logic [5:0]    vel_q,       vel_d;
   logic [11:0]   xpos_q,      xpos_d;
   logic [11:0]   ypos_q,      ypos_d;
   logic          facing_q,    facing_d;
   logic          moving_q,    moving_d;
   logic          airborne_q,  airborne_d;
   logic          jump_prev_q, jump_prev_d;

   // Combinational helpers
   logic          key_left;
   logic          key_right;
   logic          key_jump;
   logic          left_held;
   logic          right_held;
   logic          jump_held;
   logic          jump_accept;
   logic          step_due;
   logic          tick_due;
   logic [12:0]   top_plus_vel;
   logic [11:0]   rise_y;
   logic [6:0]    vel_inc;
   logic [5:0]    fall_v;
   logic [12:0]   fall_sum;
   logic          land;

   // Decode the ASCII key into movement intents
   always_comb begin
      key_left  = 1'b0;
      key_right = 1'b0;
      key_jump  = 1'b0;
      case (keyCode)
         7'd65, 7'd97:          key_left  = 1'b1;
         7'd68, 7'd100:         key_right = 1'b1;
         7'd87, 7'd119, 7'd32:  key_jump  = 1'b1;
         default: begin
            key_left  = 1'b0;
            key_right = 1'b0;
            key_jump  = 1'b0;
         end
      endcase
   end

   assign left_held  = key_left  & ~released;
   assign right_held = key_right & ~released;
   assign jump_held  = key_jump  & ~released;

   // Horizontal FSM next state; left/right switch directly without idling
   always_comb begin
      h_state_d = h_state_q;
      if (released) begin
         h_state_d = H_IDLE;
      end else begin
         case (h_state_q)
            H_IDLE: begin
               if (left_held)       h_state_d = H_LEFT;
               else if (right_held) h_state_d = H_RIGHT;
               else                 h_state_d = H_IDLE;
            end
            H_LEFT: begin
               if (right_held) h_state_d = H_RIGHT;
               else            h_state_d = H_LEFT;
            end
            H_RIGHT: begin
               if (left_held) h_state_d = H_LEFT;
               else           h_state_d = H_RIGHT;
            end
            default: h_state_d = H_IDLE;
         endcase
      end
   end

   assign step_due = (h_state_q != H_IDLE) && (step_cnt_q == STEP_LAST);

   // Step counter, x position (clamped) and facing/moving flags
   always_comb begin
      step_cnt_d = step_cnt_q + STEP_ONE;
      xpos_d     = xpos_q;
      facing_d   = facing_q;
      moving_d   = (h_state_d != H_IDLE);

      // Idle, a fresh entry or a direction switch restarts the step period
      if ((h_state_d == H_IDLE) || (h_state_d != h_state_q) || step_due) begin
         step_cnt_d = '0;
      end else begin
         step_cnt_d = step_cnt_q + STEP_ONE;
      end

      if (step_due && (h_state_q == H_LEFT) && (xpos_q != X_MIN_C)) begin
         xpos_d = xpos_q - 12'd1;
      end else if (step_due && (h_state_q == H_RIGHT) && (xpos_q != X_MAX_C)) begin
         xpos_d = xpos_q + 12'd1;
      end else begin
         xpos_d = xpos_q;
      end

      if (h_state_d == H_LEFT) begin
         facing_d = 1'b1;
      end else if (h_state_d == H_RIGHT) begin
         facing_d = 1'b0;
      end else begin
         facing_d = facing_q;
      end
   end

   assign jump_prev_d = jump_held;
   assign jump_accept = (v_state_q == V_GROUND) && jump_held && !jump_prev_q;
   assign tick_due    = (v_state_q != V_GROUND) && (tick_cnt_q == TICK_LAST);

   // Rise: 13-bit compare so ypos - vel can never wrap below the top clamp
   assign top_plus_vel = Y_TOP_W + {7'd0, vel_q};
   assign rise_y       = ({1'b0, ypos_q} < top_plus_vel) ? Y_TOP_C
                                                         : (ypos_q - {6'd0, vel_q});

   // Fall: accelerate up to terminal velocity, land when reaching the ground
   assign vel_inc  = {1'b0, vel_q} + 7'd1;
   assign fall_v   = (vel_inc > V_MAX_W) ? V_MAX_C : vel_inc[5:0];
   assign fall_sum = {1'b0, ypos_q} + {7'd0, fall_v};
   assign land     = (fall_sum >= Y_GROUND_W);

   // Vertical FSM: jump accept, tick counter, velocity and y position
   always_comb begin
      v_state_d  = v_state_q;
      vel_d      = vel_q;
      ypos_d     = ypos_q;
      tick_cnt_d = tick_cnt_q;

      case (v_state_q)
         V_GROUND: begin
            tick_cnt_d = '0;
            if (jump_accept) begin
               vel_d     = JUMP_V0_C;
               v_state_d = V_RISING;
            end else begin
               vel_d     = 6'd0;
               v_state_d = V_GROUND;
            end
         end
         V_RISING: begin
            if (tick_due) begin
               tick_cnt_d = '0;
               ypos_d     = rise_y;
               if (vel_q <= 6'd1) begin
                  vel_d     = 6'd0;
                  v_state_d = V_FALLING;
               end else begin
                  vel_d     = vel_q - 6'd1;
               end
            end else begin
               tick_cnt_d = tick_cnt_q + TICK_ONE;
            end
         end
         V_FALLING: begin
            if (tick_due) begin
               tick_cnt_d = '0;
               if (land) begin
                  ypos_d    = Y_GROUND_C;
                  vel_d     = 6'd0;
                  v_state_d = V_GROUND;
               end else begin
                  ypos_d    = fall_sum[11:0];
                  vel_d     = fall_v;
               end
            end else begin
               tick_cnt_d = tick_cnt_q + TICK_ONE;
            end
         end
         default: begin
            v_state_d  = V_GROUND;
            vel_d      = 6'd0;
            ypos_d     = Y_GROUND_C;
            tick_cnt_d = '0;
         end
      endcase

      airborne_d = (v_state_d != V_GROUND);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         h_state_q   <= H_IDLE;
         v_state_q   <= V_GROUND;
         step_cnt_q  <= '0;
         tick_cnt_q  <= '0;
         vel_q       <= 6'd0;
         xpos_q      <= X_INIT_C;
         ypos_q      <= Y_GROUND_C;
         facing_q    <= 1'b0;
         moving_q    <= 1'b0;
         airborne_q  <= 1'b0;
         jump_prev_q <= 1'b0;
      end else begin
         h_state_q   <= h_state_d;
         v_state_q   <= v_state_d;
         step_cnt_q  <= step_cnt_d;
         tick_cnt_q  <= tick_cnt_d;
         vel_q       <= vel_d;
         xpos_q      <= xpos_d;
         ypos_q      <= ypos_d;
         facing_q    <= facing_d;
         moving_q    <= moving_d;
         airborne_q  <= airborne_d;
         jump_prev_q <= jump_prev_d;
      end
   end

   assign xpos        = xpos_q;
   assign ypos        = ypos_q;
   assign moving      = moving_q;
   assign facing_left = facing_q;
   assign airborne    = airborne_q;

endmodule

// File: tb/tb_player_motion.sv
// -----------------------------------------------------------------------------
// tb_player_motion
//   Directed testbench for player_motion. Three instances with different
//   parameter sets share one clock and reset:
//     u_a : STEP_DIV=3, X_INIT=10, jump arc V0=3/VMAX=3/JUMP_DIV=1, ground 100
//     u_b : STEP_DIV=1, X_INIT=1, X_MAX=3 (both horizontal clamps)
//     u_c : as u_a but Y_TOP=95 (top clamp of the arc)
// -----------------------------------------------------------------------------
module tb_player_motion;

   logic        clk;
   logic        rst;

   logic [6:0]  kc_a, kc_b, kc_c;
   logic        rel_a, rel_b, rel_c;
   logic [11:0] xpos_a, xpos_b, xpos_c;
   logic [11:0] ypos_a, ypos_b, ypos_c;
   logic        mov_a, mov_b, mov_c;
   logic        face_a, face_b, face_c;
   logic        air_a, air_b, air_c;

   int n_checks;
   int n_pass;

   player_motion #(
      .STEP_DIV(3), .JUMP_DIV(1), .X_MIN(0), .X_MAX(1000), .Y_TOP(0),
      .Y_GROUND(100), .X_INIT(10), .JUMP_V0(3), .V_MAX(3)
   ) u_a (
      .clk(clk), .rst(rst), .keyCode(kc_a), .released(rel_a),
      .xpos(xpos_a), .ypos(ypos_a), .moving(mov_a),
      .facing_left(face_a), .airborne(air_a)
   );

   player_motion #(
      .STEP_DIV(1), .JUMP_DIV(1), .X_MIN(0), .X_MAX(3), .Y_TOP(0),
      .Y_GROUND(100), .X_INIT(1), .JUMP_V0(3), .V_MAX(3)
   ) u_b (
      .clk(clk), .rst(rst), .keyCode(kc_b), .released(rel_b),
      .xpos(xpos_b), .ypos(ypos_b), .moving(mov_b),
      .facing_left(face_b), .airborne(air_b)
   );

   player_motion #(
      .STEP_DIV(3), .JUMP_DIV(1), .X_MIN(0), .X_MAX(1000), .Y_TOP(95),
      .Y_GROUND(100), .X_INIT(10), .JUMP_V0(3), .V_MAX(3)
   ) u_c (
      .clk(clk), .rst(rst), .keyCode(kc_c), .released(rel_c),
      .xpos(xpos_c), .ypos(ypos_c), .moving(mov_c),
      .facing_left(face_c), .airborne(air_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle before sampling
   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step_clk();
      step_clk();
      n_checks++;
      if (xpos_a !== 12'd10 || ypos_a !== 12'd100 || mov_a !== 1'b0 ||
          face_a !== 1'b0 || air_a !== 1'b0) begin
         $display("FAIL reset_a x=%0d y=%0d mov=%b face=%b air=%b expected 10 100 0 0 0",
                  xpos_a, ypos_a, mov_a, face_a, air_a);
      end else n_pass++;
      n_checks++;
      if (xpos_b !== 12'd1 || ypos_b !== 12'd100 || mov_b !== 1'b0 || air_b !== 1'b0) begin
         $display("FAIL reset_b x=%0d y=%0d mov=%b air=%b expected 1 100 0 0",
                  xpos_b, ypos_b, mov_b, air_b);
      end else n_pass++;
      n_checks++;
      if (xpos_c !== 12'd10 || ypos_c !== 12'd100 || air_c !== 1'b0) begin
         $display("FAIL reset_c x=%0d y=%0d air=%b expected 10 100 0", xpos_c, ypos_c, air_c);
      end else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_step_right();
      logic [11:0] exp_x;
      kc_a  = 7'd100;
      rel_a = 1'b0;
      step_clk();
      n_checks++;
      if (xpos_a !== 12'd10 || mov_a !== 1'b1 || face_a !== 1'b0) begin
         $display("FAIL right_entry x=%0d mov=%b face=%b expected 10 1 0", xpos_a, mov_a, face_a);
      end else n_pass++;
      for (int i = 1; i <= 20; i++) begin
         step_clk();
         exp_x = 12'd10 + 12'(i / 4);
         n_checks++;
         if (xpos_a !== exp_x || mov_a !== 1'b1 || face_a !== 1'b0) begin
            $display("FAIL right_step[%0d] x=%0d mov=%b face=%b expected x=%0d mov=1 face=0",
                     i, xpos_a, mov_a, face_a, exp_x);
         end else n_pass++;
      end
      rel_a = 1'b1;
      step_clk();
      n_checks++;
      if (xpos_a !== 12'd15 || mov_a !== 1'b0 || face_a !== 1'b0) begin
         $display("FAIL right_release x=%0d mov=%b face=%b expected 15 0 0", xpos_a, mov_a, face_a);
      end else n_pass++;
   endtask

   task automatic test_switch();
      logic [11:0] exp_x;
      kc_a  = 7'd68;
      rel_a = 1'b0;
      step_clk();
      step_clk();
      step_clk();
      kc_a = 7'd65;
      step_clk();
      n_checks++;
      if (xpos_a !== 12'd15 || mov_a !== 1'b1 || face_a !== 1'b1) begin
         $display("FAIL switch_entry x=%0d mov=%b face=%b expected 15 1 1", xpos_a, mov_a, face_a);
      end else n_pass++;
      for (int i = 1; i <= 4; i++) begin
         step_clk();
         exp_x = (i == 4) ? 12'd14 : 12'd15;
         n_checks++;
         if (xpos_a !== exp_x) begin
            $display("FAIL switch_step[%0d] x=%0d expected %0d", i, xpos_a, exp_x);
         end else n_pass++;
      end
      rel_a = 1'b1;
      step_clk();
   endtask

   task automatic test_clamp();
      logic [11:0] exp_x;
      kc_b  = 7'd97;
      rel_b = 1'b0;
      step_clk();
      n_checks++;
      if (xpos_b !== 12'd1 || mov_b !== 1'b1 || face_b !== 1'b1) begin
         $display("FAIL left_entry x=%0d mov=%b face=%b expected 1 1 1", xpos_b, mov_b, face_b);
      end else n_pass++;
      for (int i = 1; i <= 10; i++) begin
         step_clk();
         exp_x = (i >= 2) ? 12'd0 : 12'd1;
         n_checks++;
         if (xpos_b !== exp_x || mov_b !== 1'b1 || face_b !== 1'b1) begin
            $display("FAIL left_clamp[%0d] x=%0d mov=%b face=%b expected x=%0d mov=1 face=1",
                     i, xpos_b, mov_b, face_b, exp_x);
         end else n_pass++;
      end
      kc_b = 7'd100;
      step_clk();
      for (int i = 1; i <= 10; i++) begin
         step_clk();
         exp_x = (i / 2 >= 3) ? 12'd3 : 12'(i / 2);
         n_checks++;
         if (xpos_b !== exp_x || mov_b !== 1'b1 || face_b !== 1'b0) begin
            $display("FAIL right_clamp[%0d] x=%0d mov=%b face=%b expected x=%0d mov=1 face=0",
                     i, xpos_b, mov_b, face_b, exp_x);
         end else n_pass++;
      end
      rel_b = 1'b1;
      step_clk();
   endtask

   task automatic test_jump_arc();
      logic [11:0] exp_y [12];
      logic        exp_air;
      exp_y = '{12'd100, 12'd97, 12'd97, 12'd95, 12'd95, 12'd94,
                12'd94,  12'd95, 12'd95, 12'd97, 12'd97, 12'd100};
      kc_a  = 7'd32;
      rel_a = 1'b0;
      step_clk();
      n_checks++;
      if (air_a !== 1'b1 || ypos_a !== 12'd100) begin
         $display("FAIL jump_accept air=%b y=%0d expected 1 100", air_a, ypos_a);
      end else n_pass++;
      for (int i = 1; i <= 12; i++) begin
         step_clk();
         exp_air = (i < 12);
         n_checks++;
         if (ypos_a !== exp_y[i-1] || air_a !== exp_air) begin
            $display("FAIL jump_arc[%0d] y=%0d air=%b expected y=%0d air=%b",
                     i, ypos_a, air_a, exp_y[i-1], exp_air);
         end else n_pass++;
      end
   endtask

   task automatic test_rejump_and_reset();
      for (int i = 0; i < 6; i++) step_clk();
      n_checks++;
      if (air_a !== 1'b0 || ypos_a !== 12'd100) begin
         $display("FAIL held_no_rejump air=%b y=%0d expected 0 100", air_a, ypos_a);
      end else n_pass++;
      rel_a = 1'b1;
      step_clk();
      rel_a = 1'b0;
      step_clk();
      n_checks++;
      if (air_a !== 1'b1) begin
         $display("FAIL rejump_accept air=%b expected 1", air_a);
      end else n_pass++;
      step_clk();
      step_clk();
      n_checks++;
      if (ypos_a !== 12'd97) begin
         $display("FAIL rejump_tick1 y=%0d expected 97", ypos_a);
      end else n_pass++;
      // A fresh press while airborne must not restart the arc
      rel_a = 1'b1;
      step_clk();
      rel_a = 1'b0;
      step_clk();
      n_checks++;
      if (ypos_a !== 12'd95 || air_a !== 1'b1) begin
         $display("FAIL air_press_ignored y=%0d air=%b expected 95 1", ypos_a, air_a);
      end else n_pass++;
      rst   = 1'b1;
      rel_a = 1'b1;
      step_clk();
      n_checks++;
      if (ypos_a !== 12'd100 || air_a !== 1'b0 || xpos_a !== 12'd10) begin
         $display("FAIL reset_mid_arc y=%0d air=%b x=%0d expected 100 0 10", ypos_a, air_a, xpos_a);
      end else n_pass++;
      rst = 1'b0;
      step_clk();
   endtask

   task automatic test_top_clamp();
      logic [11:0] exp_y [12];
      logic        exp_air;
      exp_y = '{12'd100, 12'd97, 12'd97, 12'd95, 12'd95, 12'd95,
                12'd95,  12'd96, 12'd96, 12'd98, 12'd98, 12'd100};
      kc_c  = 7'd119;
      rel_c = 1'b0;
      step_clk();
      n_checks++;
      if (air_c !== 1'b1) begin
         $display("FAIL top_accept air=%b expected 1", air_c);
      end else n_pass++;
      for (int i = 1; i <= 12; i++) begin
         step_clk();
         exp_air = (i < 12);
         n_checks++;
         if (ypos_c !== exp_y[i-1] || air_c !== exp_air) begin
            $display("FAIL top_clamp[%0d] y=%0d air=%b expected y=%0d air=%b",
                     i, ypos_c, air_c, exp_y[i-1], exp_air);
         end else n_pass++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst   = 1'b1;
      kc_a  = 7'd0;
      kc_b  = 7'd0;
      kc_c  = 7'd0;
      rel_a = 1'b1;
      rel_b = 1'b1;
      rel_c = 1'b1;

      test_reset();
      test_step_right();
      test_switch();
      test_clamp();
      test_jump_arc();
      test_rejump_and_reset();
      test_top_clamp();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
